// File: rtl/load_store_unit_if.sv
// Bus bundle between the core/data-memory side and the load/store unit.
// The slave modport is the load/store unit; the master modport is the
// environment that drives requests and models the data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_read, req_write, funct3, addr, wdata, mem_read_data,
        output stall, load_data, load_valid, access_err,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_read, req_write, funct3, addr, wdata, mem_read_data,
        input  stall, load_data, load_valid, access_err,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RISC-V loads and stores into
// word accesses on a registered-read data memory. Sub-word stores use
// read-modify-write; loads are lane-selected and sign/zero extended.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_WAIT = 3'd1,
        LOAD_RESP = 3'd2,
        RMW_WAIT  = 3'd3,
        RMW_WRITE = 3'd4
    } state_t;

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic [31:0] wdata_r;
    logic [31:0] merged_r;
    logic [31:0] load_data_r;

    logic        req_bad_s;
    logic        accept_s;
    logic        stall_s;
    logic        load_valid_s;
    logic        access_err_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic [31:0] mem_address_s;
    logic [31:0] mem_write_data_s;

    // Pick the addressed byte/halfword out of a memory word and extend it.
    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{byte_v[7]}}, byte_v};
            3'b001:  result = {{16{half_v[15]}}, half_v};
            3'b010:  result = word;
            3'b100:  result = {24'd0, byte_v};
            3'b101:  result = {16'd0, half_v};
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    // Replace the addressed byte (SB) or halfword (SH) of the old word.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3,
                                                input logic [31:0] data);
        logic [31:0] result;
        result = old_word;
        if (f3 == 3'b000) begin
            result[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            result[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return result;
    endfunction

    // Request legality: encoding, alignment and word-index range.
    always_comb begin
        req_bad_s = 1'b0;
        if (bus.req_read && bus.req_write) begin
            req_bad_s = 1'b1;
        end else if (bus.req_read || bus.req_write) begin
            if (bus.req_read && (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 ||
                                 bus.funct3 == 3'b111)) begin
                req_bad_s = 1'b1;
            end else if (bus.req_write && bus.funct3 >= 3'b011) begin
                req_bad_s = 1'b1;
            end else if (bus.funct3[1:0] == 2'b01 && bus.addr[0]) begin
                req_bad_s = 1'b1;
            end else if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00) begin
                req_bad_s = 1'b1;
            end else if (bus.addr[31:2] >= MEM_LIMIT) begin
                req_bad_s = 1'b1;
            end else begin
                req_bad_s = 1'b0;
            end
        end else begin
            req_bad_s = 1'b0;
        end
    end

    // Next-state and memory/core control outputs.
    always_comb begin
        next_state_s     = state_r;
        accept_s         = 1'b0;
        stall_s          = 1'b0;
        load_valid_s     = 1'b0;
        access_err_s     = 1'b0;
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        mem_address_s    = 32'd0;
        mem_write_data_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (!bus.req_valid) begin
                    next_state_s = IDLE;
                end else if (req_bad_s) begin
                    access_err_s = 1'b1;
                end else if (bus.req_read) begin
                    mem_read_s    = 1'b1;
                    stall_s       = 1'b1;
                    mem_address_s = {2'b00, bus.addr[31:2]};
                    accept_s      = 1'b1;
                    next_state_s  = LOAD_WAIT;
                end else if (bus.req_write && bus.funct3 == 3'b010) begin
                    mem_write_s      = 1'b1;
                    mem_address_s    = {2'b00, bus.addr[31:2]};
                    mem_write_data_s = bus.wdata;
                end else if (bus.req_write) begin
                    mem_read_s    = 1'b1;
                    stall_s       = 1'b1;
                    mem_address_s = {2'b00, bus.addr[31:2]};
                    accept_s      = 1'b1;
                    next_state_s  = RMW_WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                stall_s       = 1'b1;
                mem_address_s = {2'b00, addr_r[31:2]};
                next_state_s  = LOAD_RESP;
            end
            LOAD_RESP: begin
                load_valid_s = 1'b1;
                next_state_s = IDLE;
            end
            RMW_WAIT: begin
                stall_s       = 1'b1;
                mem_address_s = {2'b00, addr_r[31:2]};
                next_state_s  = RMW_WRITE;
            end
            RMW_WRITE: begin
                mem_write_s      = 1'b1;
                mem_address_s    = {2'b00, addr_r[31:2]};
                mem_write_data_s = merged_r;
                next_state_s     = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, RMW merge and formatted load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r      <= 32'd0;
            funct3_r    <= 3'd0;
            wdata_r     <= 32'd0;
            merged_r    <= 32'd0;
            load_data_r <= 32'd0;
        end else begin
            if (accept_s) begin
                addr_r   <= bus.addr;
                funct3_r <= bus.funct3;
                wdata_r  <= bus.wdata;
            end
            if (state_r == LOAD_WAIT) begin
                load_data_r <= format_load(bus.mem_read_data, addr_r[1:0], funct3_r);
            end
            if (state_r == RMW_WAIT) begin
                merged_r <= merge_store(bus.mem_read_data, addr_r[1:0], funct3_r, wdata_r);
            end
        end
    end

    assign bus.stall          = stall_s;
    assign bus.load_data      = load_data_r;
    assign bus.load_valid     = load_valid_s;
    assign bus.access_err     = access_err_s;
    assign bus.mem_read       = mem_read_s;
    assign bus.mem_write      = mem_write_s;
    assign bus.mem_address    = mem_address_s;
    assign bus.mem_write_data = mem_write_data_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic.
// A reference model (byte arithmetic on a word array) predicts each
// instruction's outcome; a monitor compares DUT events in order.
module tb_load_store_unit;

    localparam logic [1:0] EV_LOAD  = 2'd0;
    localparam logic [1:0] EV_ERR   = 2'd1;
    localparam logic [1:0] EV_WRITE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [31:0] waddr;
    } ev_t;

    logic clk;
    logic reset;
    logic mem_clear;
    int   vectors;
    int   miscompares;
    ev_t  exp_q[$];
    logic stall_log[$];
    logic [31:0] model_mem [64];
    logic [31:0] tb_mem [64];

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, write on rising edge.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'd0;
            bus.mem_read_data <= 32'd0;
        end else begin
            if (bus.mem_write) tb_mem[bus.mem_address[5:0]] <= bus.mem_write_data;
            if (bus.mem_read) bus.mem_read_data <= tb_mem[bus.mem_address[5:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input bit rd, input bit wr, input int f3, input int unsigned a);
        int unsigned size;
        if (rd && wr) return 1'b1;
        if (!rd && !wr) return 1'b0;
        if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (wr && f3 >= 3) return 1'b1;
        size = 1 << (f3 % 4);
        if (a % size != 0) return 1'b1;
        if (a / 4 >= 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input int f3);
        logic [31:0] shifted;
        logic [31:0] b;
        logic [31:0] h;
        shifted = word >> (8 * off);
        b = shifted & 32'h0000_00FF;
        h = shifted & 32'h0000_FFFF;
        case (f3)
            0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            4: return b;
            5: return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input int off,
                                                input int f3, input logic [31:0] wd);
        logic [31:0] mask;
        if (f3 == 2) return wd;
        mask = (f3 == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    endfunction

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one instruction, push its predicted event, hold until stall drops.
    task automatic issue(input bit rd, input bit wr, input int f3,
                         input logic [31:0] a, input logic [31:0] wd);
        ev_t e;
        bit  err;
        bit  done;
        int  stalls;
        int  exp_stalls;
        int  idx;
        err = model_err(rd, wr, f3, a);
        idx = int'(a / 4);
        e.data  = 32'd0;
        e.waddr = 32'd0;
        if (err) begin
            e.kind = EV_ERR;
            exp_stalls = 0;
        end else if (rd) begin
            e.kind = EV_LOAD;
            e.data = model_load(model_mem[idx], int'(a % 4), f3);
            exp_stalls = 2;
        end else begin
            e.kind  = EV_WRITE;
            e.data  = model_store(model_mem[idx], int'(a % 4), f3, wd);
            e.waddr = a / 4;
            model_mem[idx] = e.data;
            exp_stalls = (f3 == 2) ? 0 : 2;
        end
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.funct3    = 3'(f3);
        bus.addr      = a;
        bus.wdata     = wd;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (err) begin
                    check("err_no_access", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
                end else begin
                    check("first_mem_read", {31'd0, bus.mem_read}, {31'd0, rd || f3 != 2});
                    check("first_mem_write", {31'd0, bus.mem_write}, {31'd0, wr && f3 == 2});
                    check("first_mem_address", bus.mem_address, a / 4);
                end
            end
            stall_log.push_back(bus.stall);
            if (bus.stall) stalls++;
            else done = 1'b1;
        end
        check("stall_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        check("stall_cycles", stalls, exp_stalls);
    endtask

    // Monitor: compare every DUT output event against the scoreboard.
    always @(negedge clk) begin
        if (!reset && !mem_clear) begin
            if (bus.mem_read && bus.mem_write) begin
                check("read_write_both", 32'd1, 32'd0);
            end
            if (!bus.req_valid) begin
                check("idle_outputs",
                      {27'd0, bus.stall, bus.load_valid, bus.access_err, bus.mem_read, bus.mem_write}, 32'd0);
                check("idle_mem_address", bus.mem_address, 32'd0);
                check("idle_mem_write_data", bus.mem_write_data, 32'd0);
            end
            if (bus.load_valid || bus.access_err || bus.mem_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    logic [1:0] act_kind;
                    e = exp_q.pop_front();
                    act_kind = bus.load_valid ? EV_LOAD : (bus.access_err ? EV_ERR : EV_WRITE);
                    check("event_kind", {30'd0, act_kind}, {30'd0, e.kind});
                    if (e.kind == EV_LOAD && act_kind == EV_LOAD) begin
                        check("load_data", bus.load_data, e.data);
                        check("load_stall", {31'd0, bus.stall}, 32'd0);
                    end else if (e.kind == EV_WRITE && act_kind == EV_WRITE) begin
                        check("write_address", bus.mem_address, e.waddr);
                        check("write_data", bus.mem_write_data, e.data);
                    end else if (e.kind == EV_ERR && act_kind == EV_ERR) begin
                        check("err_quiet", {29'd0, bus.stall, bus.mem_read, bus.mem_write}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_pat [7];
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        reset     = 1'b1;
        mem_clear = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.funct3    = 3'd0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {27'd0, bus.stall, bus.load_valid, bus.access_err, bus.mem_read, bus.mem_write}, 32'd0);
        check("reset_load_data", bus.load_data, 32'd0);
        @(posedge clk);
        #1;

        // Word store then load.
        issue(1'b0, 1'b1, 2, 32'h20, 32'hABCD_1234);
        issue(1'b1, 1'b0, 2, 32'h20, 32'd0);
        // Byte RMW and extension.
        issue(1'b0, 1'b1, 0, 32'h21, 32'h0000_00FF);
        issue(1'b1, 1'b0, 0, 32'h21, 32'd0);
        issue(1'b1, 1'b0, 4, 32'h21, 32'd0);
        idle(2);
        // Half RMW and extension.
        issue(1'b0, 1'b1, 2, 32'h20, 32'd0);
        issue(1'b0, 1'b1, 1, 32'h22, 32'h0000_8001);
        issue(1'b1, 1'b0, 1, 32'h22, 32'd0);
        issue(1'b1, 1'b0, 5, 32'h22, 32'd0);
        // Rejected requests.
        issue(1'b1, 1'b0, 2, 32'h21, 32'd0);
        issue(1'b0, 1'b1, 1, 32'h23, 32'h1111_1111);
        issue(1'b1, 1'b0, 2, 32'h100, 32'd0);
        issue(1'b1, 1'b1, 2, 32'h20, 32'h2222_2222);
        idle(1);

        // Reset while an SB sits in RMW_WAIT.
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b1;
        bus.funct3    = 3'd0;
        bus.addr      = 32'h20;
        bus.wdata     = 32'h0000_0055;
        @(negedge clk);
        check("rmw_abort_read", {30'd0, bus.stall, bus.mem_read}, 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs",
              {27'd0, bus.stall, bus.load_valid, bus.access_err, bus.mem_read, bus.mem_write}, 32'd0);
        check("post_reset_load_data", bus.load_data, 32'd0);
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 2, 32'h20, 32'd0);

        // Back-to-back SW, SB, LW.
        stall_log.delete();
        issue(1'b0, 1'b1, 2, 32'h30, 32'h1122_3344);
        issue(1'b0, 1'b1, 0, 32'h31, 32'h0000_00AA);
        issue(1'b1, 1'b0, 2, 32'h30, 32'd0);
        exp_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        check("b2b_stall_len", stall_log.size(), 7);
        for (int i = 0; i < 7 && i < stall_log.size(); i++) begin
            check("b2b_stall_pattern", {31'd0, stall_log[i]}, {31'd0, exp_pat[i]});
        end
        idle(1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int sel;
            int f3;
            bit rd;
            bit wr;
            logic [31:0] a;
            sel = $urandom_range(0, 19);
            rd  = (sel <= 10);
            wr  = (sel == 0) || (sel > 10);
            if ($urandom_range(0, 3) == 0) begin
                f3 = $urandom_range(0, 7);
            end else if (rd && !wr) begin
                case ($urandom_range(0, 4))
                    0: f3 = 0;
                    1: f3 = 1;
                    2: f3 = 2;
                    3: f3 = 4;
                    default: f3 = 5;
                endcase
            end else begin
                f3 = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(256, 300));
            else a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) a = a & ~32'(((1 << (f3 % 4)) - 1));
            issue(rd, wr, f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 64; i++) begin
            check("final_memory", tb_mem[i], model_mem[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
